// File: rtl/product_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : product_divider_pkg
//  Description : Shared widths, FSM state encoding and counter sizing for the
//                product_divider restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package product_divider_pkg;

   // Default operand widths for the divider and its step sub-module
   localparam int P_WIDTH_DEF = 8;
   localparam int D_WIDTH_DEF = 4;

   // Iteration counter must be able to hold the value P_WIDTH itself
   localparam int CNT_WIDTH = $clog2(P_WIDTH_DEF + 1);

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width for an arbitrary dividend width
   function automatic int cnt_width(input int p_width);
      return $clog2(p_width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/product_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step. Appends the next
//                dividend bit to the running remainder and subtracts the
//                divisor whenever it fits.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
   import product_divider_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic [D_WIDTH-1:0] rem_in,
   input  logic               dividend_bit,
   input  logic [D_WIDTH-1:0] divisor,
   output logic [D_WIDTH-1:0] rem_out,
   output logic               q_bit
);

   logic [D_WIDTH:0] partial;
   logic [D_WIDTH:0] diff;

   // Trial subtraction on the one-bit-wider partial remainder; the result is
   // always below the divisor so it fits back into D_WIDTH bits
   always_comb begin
      partial = {rem_in, dividend_bit};
      diff    = partial - {1'b0, divisor};
      q_bit   = (partial >= {1'b0, divisor});
      rem_out = q_bit ? diff[D_WIDTH-1:0] : partial[D_WIDTH-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/product_divider.sv
`default_nettype none
// ============================================================================
//  Module      : product_divider
//  Description : Sequential restoring divider, one quotient bit per cycle,
//                MSB first. Divide-by-zero short-circuits straight to DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module product_divider
   import product_divider_pkg::*;
#(
   parameter int P_WIDTH = P_WIDTH_DEF,
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [P_WIDTH-1:0] product,
   input  logic [D_WIDTH-1:0] divisor,
   output logic               busy,
   output logic               done,
   output logic [P_WIDTH-1:0] quotient,
   output logic [D_WIDTH-1:0] remainder,
   output logic               div_by_zero,
   output logic               exact
);

   localparam int               CNT_W      = cnt_width(P_WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(P_WIDTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   state_t             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [P_WIDTH-1:0] dividend_q, dividend_d;
   logic [D_WIDTH-1:0] dvsr_q,     dvsr_d;
   logic [P_WIDTH-1:0] quot_q,     quot_d;
   logic [D_WIDTH-1:0] rem_q,      rem_d;
   logic               dbz_q,      dbz_d;
   logic               exact_q,    exact_d;

   logic [D_WIDTH-1:0] step_rem;
   logic               step_qbit;

   div_step #(
      .D_WIDTH (D_WIDTH)
   ) u_div_step (
      .rem_in       (rem_q),
      .dividend_bit (dividend_q[P_WIDTH-1]),
      .divisor      (dvsr_q),
      .rem_out      (step_rem),
      .q_bit        (step_qbit)
   );

   // Next-state and datapath update; start is only honoured when not in RUN
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      dvsr_d     = dvsr_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      exact_d    = exact_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               quot_d  = '0;
               rem_d   = '0;
               dbz_d   = 1'b0;
               exact_d = 1'b0;
               if (divisor == '0) begin
                  // No iterations needed: publish the saturated result now
                  state_d = DONE;
                  cnt_d   = '0;
                  quot_d  = '1;
                  dbz_d   = 1'b1;
               end else begin
                  state_d    = RUN;
                  cnt_d      = C_CNT_LOAD;
                  dividend_d = product;
                  dvsr_d     = divisor;
               end
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            dividend_d = dividend_q << 1;
            quot_d     = {quot_q[P_WIDTH-2:0], step_qbit};
            rem_d      = step_rem;
            cnt_d      = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
               state_d = DONE;
               exact_d = (step_rem == '0);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over every other event
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dividend_q <= '0;
         dvsr_q     <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
         exact_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         dvsr_q     <= dvsr_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
         exact_q    <= exact_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign exact       = exact_q;

endmodule
`default_nettype wire

// File: tb/tb_product_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_product_divider
//  Description : Self-checking bench for product_divider: arithmetic reference
//                model compared every cycle plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_product_divider;

   localparam int P = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [P-1:0] product = '0;
   logic [D-1:0] divisor = '0;
   logic         busy, done, div_by_zero, exact;
   logic [P-1:0] quotient;
   logic [D-1:0] remainder;

   int n_checks = 0;
   int n_fail   = 0;

   product_divider #(.P_WIDTH(P), .D_WIDTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .product     (product),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .exact       (exact)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain arithmetic) ----------------
   int cyc = 0;
   bit m_valid = 0;
   bit m_run = 0, m_done = 0;
   int m_due;
   int m_q = 0, m_r = 0, m_dbz = 0, m_ex = 0;
   int pend_q, pend_r;

   always @(posedge clk) begin
      cyc++;
      m_valid = 1;
      if (rst) begin
         m_run = 0; m_done = 0;
         m_q = 0; m_r = 0; m_dbz = 0; m_ex = 0;
      end else begin
         m_done = 0;
         if (m_run) begin
            if (cyc == m_due) begin
               m_run = 0; m_done = 1;
               m_q = pend_q; m_r = pend_r; m_dbz = 0;
               m_ex = (pend_r == 0) ? 1 : 0;
            end
         end else if (start) begin
            if (divisor == 0) begin
               m_done = 1;
               m_q = (1 << P) - 1; m_r = 0; m_dbz = 1; m_ex = 0;
            end else begin
               m_run = 1; m_due = cyc + P;
               pend_q = int'(product) / int'(divisor);
               pend_r = int'(product) % int'(divisor);
               m_q = 0; m_r = 0; m_dbz = 0; m_ex = 0;
            end
         end
      end
   end

   // Per-cycle comparison; quotient/remainder are intermediate while running
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", int'(busy), int'(m_run));
         chk("done", int'(done), int'(m_done));
         chk("div_by_zero", int'(div_by_zero), m_dbz);
         chk("exact", int'(exact), m_ex);
         if (!m_run) begin
            chk("quotient", int'(quotient), m_q);
            chk("remainder", int'(remainder), m_r);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Pulses start for one cycle and reports edges from start to visible done
   task automatic run_op(input int p, input int d, output int lat);
      product = P'(p); divisor = D'(d); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic check_result(input string tag, input int q, input int r,
                               input int dz, input int ex);
      chk({tag, "_q"}, int'(quotient), q);
      chk({tag, "_r"}, int'(remainder), r);
      chk({tag, "_dbz"}, int'(div_by_zero), dz);
      chk({tag, "_exact"}, int'(exact), ex);
   endtask

   initial begin
      int lat;
      int n_done;
      int k, wait_n;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      check_result("rst", 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);

      // 42/6: accept edge plus 8 run edges before done is visible
      run_op(42, 6, lat);
      chk("lat_42_6", lat, 9);
      check_result("d42_6", 7, 0, 0, 1);
      @(negedge clk);
      chk("done_single", int'(done), 0);

      run_op(200, 7, lat);
      check_result("d200_7", 28, 4, 0, 0);
      @(negedge clk);
      run_op(255, 1, lat);
      check_result("d255_1", 255, 0, 0, 1);
      @(negedge clk);

      // Divide by zero: done right after the accepting edge
      run_op(99, 0, lat);
      chk("lat_99_0", lat, 1);
      check_result("d99_0", 255, 0, 1, 0);
      @(negedge clk);
      chk("dbz_hold", int'(div_by_zero), 1);

      // start during RUN is ignored
      product = 8'd225; divisor = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      product = 8'd10; divisor = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            n_done++;
            check_result("d225_15", 15, 0, 0, 1);
         end
         @(negedge clk);
      end
      chk("ignored_start_done_cnt", n_done, 1);

      // Reset aborts a running division
      run_op(42, 6, lat);
      @(negedge clk);
      product = 8'd200; divisor = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      check_result("abort", 0, 0, 0, 0);
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) n_done++;
         @(negedge clk);
      end
      chk("abort_no_done", n_done, 0);
      run_op(42, 6, lat);
      chk("lat_after_abort", lat, 9);
      check_result("after_abort", 7, 0, 0, 1);
      @(negedge clk);

      // Full operand sweep in scrambled order, start held high throughout
      for (int i = 0; i < 4096; i++) begin
         k = (i * 1237) % 4096;
         product = P'(k >> 4);
         divisor = D'(k & 15);
         start = 1'b1;
         @(negedge clk);
         wait_n = 0;
         while (!m_done && wait_n < 30) begin
            @(negedge clk);
            wait_n++;
         end
         if (!m_done) chk("sweep_timeout", 0, 1);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
